// File: rtl/pueo_scaler_readout.sv
// pueo_scaler_readout: snapshots 32 scalers after each PPS and streams them as a 17-word AXI4-Stream frame
// Ports: sysclk_i/rst_n_i clock and async active-low reset; pps_i PPS pulse;
// sys_adr_o/sys_dat_i scaler read port (combinational data); m_t* stream master;
// drop_count_o saturating count of PPS events that produced no frame; busy_o FSM not idle.
module pueo_scaler_readout #(
  parameter int          UPDATE_DELAY = 40,
  parameter logic [15:0] HEADER_TAG   = 16'h5CA1
) (
  input  logic        sysclk_i,
  input  logic        rst_n_i,
  input  logic        pps_i,
  output logic [4:0]  sys_adr_o,
  input  logic [15:0] sys_dat_i,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic [15:0] drop_count_o,
  output logic        busy_o
);
  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, STREAM} state_t;
  state_t state, state_nxt;
  logic [7:0]  cnt;
  logic [4:0]  idx;
  logic [4:0]  wrd;
  logic [3:0]  pair;
  logic [15:0] seq, frame_seq, hdr_seq;
  logic [15:0] shadow [32];
  logic        last_ack, drop;
  assign last_ack = state == STREAM && m_tready && wrd == 5'd16;
  // a PPS coinciding with the final handshake starts the next frame instead of being dropped
  assign drop = pps_i && (state == WAIT || state == CAPTURE || (state == STREAM && !last_ack));
  assign pair = wrd[3:0] - 4'd1;
  always_ff @(posedge sysclk_i or negedge rst_n_i)
    if (!rst_n_i) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    m_tvalid  = state == STREAM;
    m_tlast   = state == STREAM && wrd == 5'd16;
    m_tdata   = '0;
    sys_adr_o = state == CAPTURE ? idx : 5'd0;
    busy_o    = state != IDLE;
    case (state)
      IDLE:    state_nxt = pps_i ? WAIT : IDLE;
      // cnt holds (cycle since PPS) - 1, so CAPTURE starts exactly UPDATE_DELAY cycles after PPS
      WAIT:    state_nxt = pps_i ? WAIT : cnt == 8'(UPDATE_DELAY - 2) ? CAPTURE : WAIT;
      CAPTURE: state_nxt = pps_i ? WAIT : idx == 5'd31 ? STREAM : CAPTURE;
      STREAM: begin
        state_nxt = !last_ack ? STREAM : pps_i ? WAIT : IDLE;
        m_tdata   = wrd == 5'd0 ? {HEADER_TAG, hdr_seq} : {shadow[{pair, 1'b1}], shadow[{pair, 1'b0}]};
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge sysclk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      cnt          <= '0;
      idx          <= '0;
      wrd          <= '0;
      seq          <= '0;
      frame_seq    <= '0;
      hdr_seq      <= '0;
      drop_count_o <= '0;
      for (int i = 0; i < 32; i++) shadow[i] <= '0;
    end else begin
      if (pps_i) begin
        frame_seq <= seq;
        seq       <= seq + 16'd1;
      end
      if (drop && drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 16'd1;
      cnt <= pps_i ? 8'd0 : state == WAIT ? cnt + 8'd1 : cnt;
      idx <= state == CAPTURE && !pps_i ? idx + 5'd1 : 5'd0;
      wrd <= state == STREAM ? wrd + 5'(m_tready) : 5'd0;
      if (state == CAPTURE) shadow[idx] <= sys_dat_i;
      // header seq is frozen at stream start so PPS events during STREAM cannot alter the frame
      if (state == CAPTURE && idx == 5'd31) hdr_seq <= frame_seq;
    end
endmodule

// File: tb/tb_pueo_scaler_readout.sv
// tb_pueo_scaler_readout: self-checking bench for pueo_scaler_readout
module tb_pueo_scaler_readout;
  localparam int UD = 40;
  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        pps_i = 1'b0;
  logic [4:0]  sys_adr_o;
  logic [15:0] sys_dat_i;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic [15:0] drop_count_o;
  logic        busy_o;
  logic [15:0] scal [32];
  logic [15:0] seq_m = '0, fseq_m = '0, next_m = '0, drop_m = '0;
  int          n_chk = 0, n_err = 0;
  bit          ch;
  typedef struct {
    int          t;
    logic [4:0]  adr;
    logic        valid;
    logic        last;
    logic        busy;
    logic [31:0] data;
  } vec_t;
  vec_t tab [11];

  pueo_scaler_readout dut (
    .sysclk_i(clk), .rst_n_i(rst_n_i), .pps_i(pps_i), .sys_adr_o(sys_adr_o),
    .sys_dat_i(sys_dat_i), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .drop_count_o(drop_count_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  assign sys_dat_i = scal[sys_adr_o];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return v == 16'hFFFF ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] exp_word(input int n);
    return n == 0 ? {16'h5CA1, fseq_m} : {scal[2*n-1], scal[2*n-2]};
  endfunction

  // Runs one frame: PPS at t=0 (or already issued the cycle before when start=1),
  // optional extra PPS at t=pps2, m_tready low until t=hold, then all-ones or random.
  task automatic deliver(input int start, input int pps2, input int hold, input bit rnd, output bit chained);
    int cb = 0, words = 0;
    bit stalled = 0, unstable = 0;
    logic [31:0] prev = '0;
    chained = 0;
    if (start == 0) begin
      pps_i  = 1'b1;
      fseq_m = seq_m;
      seq_m  = seq_m + 16'd1;
    end
    for (int t = start; words < 17 && t < 4000; t++) begin
      if (t > 0) pps_i = (t == pps2);
      m_tready = t < hold ? 1'b0 : rnd ? 1'($urandom % 2) : 1'b1;
      if (t == pps2) begin
        if (t < cb + UD + 32) begin
          drop_m = sat_inc(drop_m);
          fseq_m = seq_m;
          cb     = t;
        end else if (m_tvalid && m_tready && words == 16) begin
          next_m  = seq_m;
          chained = 1;
        end else drop_m = sat_inc(drop_m);
        seq_m = seq_m + 16'd1;
      end
      if (t == cb + UD + 5) chk("capture_adr", sys_adr_o, 5);
      if (t == cb + UD + 31) chk("tvalid_early", m_tvalid, 0);
      if (t == cb + UD + 32) chk("tvalid_rise", m_tvalid, 1);
      if (stalled && (m_tdata !== prev || !m_tvalid)) unstable = 1;
      if (m_tvalid && m_tready) begin
        chk($sformatf("word%0d", words), m_tdata, exp_word(words));
        chk($sformatf("tlast%0d", words), m_tlast, words == 16);
        words++;
        stalled = 0;
      end else begin
        stalled = m_tvalid;
        prev    = m_tdata;
      end
      tick();
    end
    pps_i = 1'b0;
    chk("frame_words", words, 17);
    chk("stall_stable", unstable, 0);
    chk("drop_count", drop_count_o, drop_m);
    if (!chained) chk("busy_after", busy_o, 0);
  endtask

  initial begin
    for (int k = 0; k < 32; k++) scal[k] = 16'h100 + 16'(k);
    tab[0]  = '{0,  5'd0,  1'b0, 1'b0, 1'b0, 32'h0};
    tab[1]  = '{1,  5'd0,  1'b0, 1'b0, 1'b1, 32'h0};
    tab[2]  = '{39, 5'd0,  1'b0, 1'b0, 1'b1, 32'h0};
    tab[3]  = '{40, 5'd0,  1'b0, 1'b0, 1'b1, 32'h0};
    tab[4]  = '{41, 5'd1,  1'b0, 1'b0, 1'b1, 32'h0};
    tab[5]  = '{71, 5'd31, 1'b0, 1'b0, 1'b1, 32'h0};
    tab[6]  = '{72, 5'd0,  1'b1, 1'b0, 1'b1, 32'h5CA10000};
    tab[7]  = '{73, 5'd0,  1'b1, 1'b0, 1'b1, 32'h01010100};
    tab[8]  = '{87, 5'd0,  1'b1, 1'b0, 1'b1, 32'h011D011C};
    tab[9]  = '{88, 5'd0,  1'b1, 1'b1, 1'b1, 32'h011F011E};
    tab[10] = '{89, 5'd0,  1'b0, 1'b0, 1'b0, 32'h0};
    repeat (3) tick();
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_adr", sys_adr_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_drop", drop_count_o, 0);
    rst_n_i = 1'b1;
    tick();
    // directed first frame against the hand-derived cycle table
    pps_i    = 1'b1;
    m_tready = 1'b1;
    seq_m    = seq_m + 16'd1;
    for (int t = 0; t <= 89; t++) begin
      for (int i = 0; i < 11; i++)
        if (tab[i].t == t)
          chk($sformatf("vec_t%0d", t), {sys_adr_o, m_tvalid, m_tlast, busy_o, m_tdata},
              {tab[i].adr, tab[i].valid, tab[i].last, tab[i].busy, tab[i].data});
      tick();
      pps_i = 1'b0;
    end
    chk("basic_drop", drop_count_o, 0);
    // random scaler contents, random back-pressure, random aborting PPS
    for (int f = 0; f < 10; f++) begin
      for (int k = 0; k < 32; k++) scal[k] = 16'($urandom);
      deliver(0, ($urandom % 2) ? int'($urandom_range(1, 71)) : -1, 0, 1, ch);
      repeat ($urandom_range(0, 5)) tick();
    end
    // long stall with a PPS during STREAM, then a fresh frame
    deliver(0, 500, 2000, 0, ch);
    deliver(0, -1, 0, 0, ch);
    // PPS during CAPTURE restarts the snapshot
    deliver(0, 60, 0, 0, ch);
    // PPS on the final handshake chains directly into the next frame
    deliver(0, 88, 0, 0, ch);
    chk("chained", ch, 1);
    chk("chain_busy", busy_o, 1);
    fseq_m = next_m;
    deliver(1, -1, 0, 0, ch);
    // reset asserted mid-stream
    pps_i = 1'b1;
    tick();
    pps_i    = 1'b0;
    m_tready = 1'b0;
    repeat (80) tick();
    chk("pre_rst_valid", m_tvalid, 1);
    rst_n_i = 1'b0;
    #1;
    chk("midrst_tvalid", m_tvalid, 0);
    chk("midrst_drop", drop_count_o, 0);
    chk("midrst_busy", busy_o, 0);
    repeat (2) tick();
    rst_n_i = 1'b1;
    seq_m   = '0;
    drop_m  = '0;
    deliver(0, -1, 0, 0, ch);
    // 65537 back-to-back PPS: seq wraps and the drop counter saturates
    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    seq_m   = '0;
    drop_m  = '0;
    pps_i   = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      fseq_m = seq_m;
      seq_m  = seq_m + 16'd1;
      if (i > 0) drop_m = sat_inc(drop_m);
      tick();
      if (i == 65535) chk("drop_sat_edge", drop_count_o, drop_m);
    end
    pps_i = 1'b0;
    chk("drop_sat", drop_count_o, drop_m);
    deliver(1, -1, 0, 0, ch);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
